windowed_register_file: RTL and testbench

- Parametrised SPARC integer register file.
- Holds 8 globals plus NWINDOWS overlapping 16-register windows.
- Owns the Current Window Pointer (CWP) and the Window Invalid Mask (WIM).
- Executes SAVE/RESTORE window rotation, raises overflow/underflow traps, and provides two read ports with same-cycle write bypass to the datapath ALU.

---
 rtl/windowed_register_file.sv | 126 ++++++++++++
 tb/tb_windowed_register_file.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/windowed_register_file.sv
// windowed_register_file
//   SPARC-style integer register file: 8 globals plus NWINDOWS overlapping
//   16-register windows. It owns CWP and WIM, performs SAVE/RESTORE window
//   rotation with overflow/underflow traps, and provides two combinational
//   read ports that bypass a same-cycle write.
// Ports
//   Clock, Reset                 rising-edge clock, async active-high reset
//   Data_In, Destination_Register, RF_Ld          write port
//   Register_A/B_Select -> Register_A/B           combinational read ports
//   Save, Restore, Write_CWP, CWP_In              window control
//   Write_WIM, WIM_In                             invalid-mask load
//   Current_Window_Pointer, WIM                   architectural state
//   Window_Overflow/Underflow/Conflict            registered one-cycle pulses
module windowed_register_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int NWINDOWS_LOG2 = 3
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [DATA_WIDTH-1:0]           Data_In,
    input  logic [4:0]                      Destination_Register,
    input  logic                            RF_Ld,
    input  logic [4:0]                      Register_A_Select,
    input  logic [4:0]                      Register_B_Select,
    output logic [DATA_WIDTH-1:0]           Register_A,
    output logic [DATA_WIDTH-1:0]           Register_B,
    input  logic                            Save,
    input  logic                            Restore,
    input  logic                            Write_CWP,
    input  logic [NWINDOWS_LOG2-1:0]        CWP_In,
    input  logic                            Write_WIM,
    input  logic [(1<<NWINDOWS_LOG2)-1:0]   WIM_In,
    output logic [NWINDOWS_LOG2-1:0]        Current_Window_Pointer,
    output logic [(1<<NWINDOWS_LOG2)-1:0]   WIM,
    output logic                            Window_Overflow,
    output logic                            Window_Underflow,
    output logic                            Window_Conflict
);
    localparam int NWINDOWS = 1 << NWINDOWS_LOG2;
    localparam int NPHYS    = 8 + 16 * NWINDOWS;
    localparam int PW       = $clog2(NPHYS);

    logic [DATA_WIDTH-1:0]    rf [NPHYS];
    logic [NWINDOWS_LOG2-1:0] cwp;
    logic [NWINDOWS-1:0]      wim;

    // Architectural index -> physical index for a given window.
    // Outs (r8..r15) live in the ins of window cwp-1; the window count is a
    // power of two so the subtraction wraps modulo NWINDOWS on its own.
    function automatic logic [PW-1:0] phys_idx(input logic [4:0] r,
                                               input logic [NWINDOWS_LOG2-1:0] w_cur);
        logic [NWINDOWS_LOG2-1:0] w;
        int base;
        w = (r[4:3] == 2'b01) ? w_cur - NWINDOWS_LOG2'(1) : w_cur;
        case (r[4:3])
            2'b00:   base = 0;                    // globals
            2'b10:   base = 16 + 16 * int'(w);    // locals
            default: base = 8 + 16 * int'(w);     // ins, and outs via w-1
        endcase
        return PW'(base + int'(r[2:0]));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [4:0] sel);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        if (Reset || sel == 5'd0)
            d = '0;
        else if (RF_Ld && Destination_Register == sel)
            d = Data_In;
        else
            d = rf[phys_idx(sel, cwp)];
        return d;
    endfunction

    always_comb begin
        Register_A = read_port(Register_A_Select);
        Register_B = read_port(Register_B_Select);
    end

    // Window control, highest priority first.
    logic [NWINDOWS_LOG2-1:0] save_tgt, restore_tgt, cwp_nxt;
    logic ovf_nxt, unf_nxt, cfl_nxt;

    always_comb begin
        save_tgt    = cwp - NWINDOWS_LOG2'(1);
        restore_tgt = cwp + NWINDOWS_LOG2'(1);
        cwp_nxt     = cwp;
        ovf_nxt     = 1'b0;
        unf_nxt     = 1'b0;
        cfl_nxt     = 1'b0;
        if (Write_CWP)
            cwp_nxt = CWP_In;
        else if (Save && Restore)
            cfl_nxt = 1'b1;
        else if (Save) begin
            if (wim[save_tgt]) ovf_nxt = 1'b1;
            else               cwp_nxt = save_tgt;
        end else if (Restore) begin
            if (wim[restore_tgt]) unf_nxt = 1'b1;
            else                  cwp_nxt = restore_tgt;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NPHYS; i++) rf[i] <= '0;
            cwp              <= '0;
            wim              <= '0;
            Window_Overflow  <= 1'b0;
            Window_Underflow <= 1'b0;
            Window_Conflict  <= 1'b0;
        end else begin
            // Write addresses through the pre-edge CWP.
            if (RF_Ld && Destination_Register != 5'd0)
                rf[phys_idx(Destination_Register, cwp)] <= Data_In;
            cwp              <= cwp_nxt;
            if (Write_WIM) wim <= WIM_In;
            Window_Overflow  <= ovf_nxt;
            Window_Underflow <= unf_nxt;
            Window_Conflict  <= cfl_nxt;
        end
    end

    assign Current_Window_Pointer = cwp;
    assign WIM                    = wim;
endmodule

// File: tb/tb_windowed_register_file.sv
module tb_windowed_register_file;
    localparam int DW  = 32;
    localparam int NWL = 3;
    localparam int NW  = 1 << NWL;

    logic          clk, rst;
    logic [DW-1:0] din, ra, rb;
    logic [4:0]    dest, sa, sb;
    logic          ld, save, restore, wcwp, wwim;
    logic [NWL-1:0] cwp_in, cwp;
    logic [NW-1:0] wim_in, wim;
    logic          ovf, unf, cfl;

    windowed_register_file #(.DATA_WIDTH(DW), .NWINDOWS_LOG2(NWL)) dut (
        .Clock(clk), .Reset(rst), .Data_In(din), .Destination_Register(dest),
        .RF_Ld(ld), .Register_A_Select(sa), .Register_B_Select(sb),
        .Register_A(ra), .Register_B(rb), .Save(save), .Restore(restore),
        .Write_CWP(wcwp), .CWP_In(cwp_in), .Write_WIM(wwim), .WIM_In(wim_in),
        .Current_Window_Pointer(cwp), .WIM(wim), .Window_Overflow(ovf),
        .Window_Underflow(unf), .Window_Conflict(cfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: globals, plus per-window ins and locals.
    // A window's outs are simply the ins of the window below it.
    logic [DW-1:0] m_g   [8];
    logic [DW-1:0] m_ins [NW][8];
    logic [DW-1:0] m_loc [NW][8];
    int            m_cwp;
    logic [NW-1:0] m_wim;
    logic          m_ovf, m_unf, m_cfl;

    function automatic logic [DW-1:0] m_read(input int r);
        if (r == 0)  return '0;
        if (r < 8)   return m_g[r];
        if (r < 16)  return m_ins[(m_cwp + NW - 1) % NW][r - 8];
        if (r < 24)  return m_loc[m_cwp][r - 16];
        return m_ins[m_cwp][r - 24];
    endfunction

    task automatic m_write(input int r, input logic [DW-1:0] d);
        if (r == 0)      ;
        else if (r < 8)  m_g[r] = d;
        else if (r < 16) m_ins[(m_cwp + NW - 1) % NW][r - 8] = d;
        else if (r < 24) m_loc[m_cwp][r - 16] = d;
        else             m_ins[m_cwp][r - 24] = d;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_g[i] = '0;
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < 8; i++) begin
                m_ins[w][i] = '0;
                m_loc[w][i] = '0;
            end
        m_cwp = 0; m_wim = '0; m_ovf = 0; m_unf = 0; m_cfl = 0;
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [4:0] s);
        if (rst || s == 0) return '0;
        if (ld && dest == s) return din;
        return m_read(int'(s));
    endfunction

    task automatic idle();
        ld = 0; save = 0; restore = 0; wcwp = 0; wwim = 0;
        din = '0; dest = '0; cwp_in = '0; wim_in = '0;
    endtask

    // Check reads against present inputs, advance model, clock, check state.
    task automatic cycle();
        int n;
        #1;
        chk("rdA", ra, exp_rd(sa));
        chk("rdB", rb, exp_rd(sb));
        if (ld) m_write(int'(dest), din);
        m_ovf = 0; m_unf = 0; m_cfl = 0;
        if (wcwp) m_cwp = int'(cwp_in);
        else if (save && restore) m_cfl = 1;
        else if (save) begin
            n = (m_cwp + NW - 1) % NW;
            if (m_wim[n]) m_ovf = 1; else m_cwp = n;
        end else if (restore) begin
            n = (m_cwp + 1) % NW;
            if (m_wim[n]) m_unf = 1; else m_cwp = n;
        end
        if (wwim) m_wim = wim_in;
        @(posedge clk);
        #1;
        chk("cwp", DW'(cwp), DW'(m_cwp));
        chk("wim", DW'(wim), DW'(m_wim));
        chk("ovf", DW'(ovf), DW'(m_ovf));
        chk("unf", DW'(unf), DW'(m_unf));
        chk("cfl", DW'(cfl), DW'(m_cfl));
    endtask

    task automatic chk_state_zero(input string tag);
        chk({tag, "_cwp"}, DW'(cwp), '0);
        chk({tag, "_wim"}, DW'(wim), '0);
        chk({tag, "_flags"}, DW'({ovf, unf, cfl}), '0);
    endtask

    initial begin
        idle();
        sa = 0; sb = 0;
        rst = 1'b1;
        m_reset();
        #2;
        for (int r = 0; r < 32; r++) begin
            sa = 5'(r); sb = 5'(31 - r);
            #1;
            chk("rst_rdA", ra, '0);
            chk("rst_rdB", rb, '0);
        end
        chk_state_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        // Outs of window 0 become ins of window 7 after SAVE.
        idle(); ld = 1; dest = 8; din = 32'hAAAA0001; cycle();
        idle(); save = 1; cycle();
        chk("save_cwp7", DW'(cwp), 32'd7);
        idle(); sa = 24; #1 chk("r24_after_save", ra, 32'hAAAA0001); cycle();
        idle(); restore = 1; cycle();
        chk("restore_cwp0", DW'(cwp), 32'd0);
        idle(); sa = 8; #1 chk("r8_after_restore", ra, 32'hAAAA0001); cycle();

        // Overflow / underflow traps, including wrap-around targets.
        idle(); wwim = 1; wim_in = 8'h80; cycle();
        idle(); save = 1; cycle();
        chk("ovf_pulse", DW'(ovf), 32'd1);
        chk("ovf_cwp_hold", DW'(cwp), 32'd0);
        idle(); cycle();
        chk("ovf_clear", DW'(ovf), 32'd0);
        idle(); wwim = 1; wim_in = 8'h02; cycle();
        idle(); restore = 1; cycle();
        chk("unf_pulse", DW'(unf), 32'd1);
        chk("unf_cwp_hold", DW'(cwp), 32'd0);
        idle(); cycle();

        // Write bypass, and r0 discard.
        idle(); ld = 1; dest = 5; din = 32'h12345678; sa = 5;
        #1 chk("bypass", ra, 32'h12345678);
        cycle();
        idle(); ld = 1; dest = 0; din = 32'hFFFFFFFF; sa = 0;
        #1 chk("bypass_r0", ra, '0);
        cycle();
        idle(); sa = 0; #1 chk("r0_after", ra, '0); cycle();

        // Conflict and Write_CWP priority.
        idle(); wwim = 1; wim_in = '0; cycle();
        idle(); save = 1; restore = 1; cycle();
        chk("conflict", DW'(cfl), 32'd1);
        chk("conflict_cwp", DW'(cwp), 32'd0);
        idle(); wcwp = 1; cwp_in = 5; save = 1; cycle();
        chk("wcwp_cwp", DW'(cwp), 32'd5);
        chk("wcwp_flags", DW'({ovf, unf, cfl}), '0);

        // Write with SAVE lands in the pre-edge window.
        idle(); wcwp = 1; cwp_in = 3; cycle();
        idle(); ld = 1; dest = 16; din = 32'hDEAD; save = 1; cycle();
        chk("save_wr_cwp", DW'(cwp), 32'd2);
        idle(); sa = 16; #1 chk("r16_new_win", ra, '0); cycle();
        idle(); restore = 1; cycle();
        idle(); sa = 16; #1 chk("r16_old_win", ra, 32'hDEAD); cycle();

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            idle();
            ld      = ($urandom_range(0, 2) != 0);
            dest    = 5'($urandom);
            din     = $urandom;
            sa      = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom);
            sb      = 5'($urandom);
            save    = ($urandom_range(0, 3) == 0);
            restore = ($urandom_range(0, 3) == 0);
            wcwp    = ($urandom_range(0, 15) == 0);
            cwp_in  = NWL'($urandom);
            wwim    = ($urandom_range(0, 11) == 0);
            wim_in  = NW'($urandom) & NW'($urandom);
            cycle();
        end

        // Mid-operation asynchronous reset, with a write pending.
        idle(); ld = 1; dest = 20; din = 32'h5555AAAA; sa = 20; sb = 9;
        #2 rst = 1'b1;
        #1;
        m_reset();
        chk("amid_rdA", ra, '0);
        chk("amid_rdB", rb, '0);
        chk_state_zero("amid");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            idle();
            sa = 5'($urandom); sb = 5'(k % 32);
            ld = ($urandom_range(0, 1) == 1); dest = 5'($urandom); din = $urandom;
            save = ($urandom_range(0, 3) == 0);
            restore = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
